// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: runs the oscillator, lets it settle, counts
// synchronized rising edges over a programmable window and reports the saturating count.
module ro_freq_meter #(
    parameter int COUNT_W       = 24,
    parameter int WIN_W         = 20,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIN_W-1:0]   window_len,
    input  logic               ro_out,
    output logic               ro_en,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] result,
    output logic               overflow
);

    localparam int TIMER_W = (WIN_W > 8) ? WIN_W : 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, DRAIN, DONE} stateT;

    stateT              state, nextState;
    logic [TIMER_W-1:0] timer, loadVal;
    logic [WIN_W-1:0]   winLat;
    logic [COUNT_W-1:0] edgeCount;
    logic               ovfCount;
    logic               sync1, sync2, sync3;
    logic               riseDet;
    logic               roEnReg;

    assign riseDet = sync2 & ~sync3;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign ro_en   = roEnReg;

    // Phase timer is reloaded on every state change and counts down to zero.
    always_comb begin
        nextState = state;
        loadVal   = '0;
        case (state)
            IDLE:   if (start && !abort) nextState = SETTLE;
            SETTLE: if (timer == '0) nextState = (winLat == '0) ? DRAIN : COUNT;
            COUNT:  if (timer == '0) nextState = DRAIN;
            DRAIN:  if (timer == '0) nextState = DONE;
            DONE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (abort && state != IDLE) nextState = IDLE;
        case (nextState)
            SETTLE:  loadVal = TIMER_W'(SETTLE_CYCLES - 1);
            COUNT:   loadVal = TIMER_W'(winLat) - TIMER_W'(1);
            DRAIN:   loadVal = TIMER_W'(2);
            default: loadVal = '0;
        endcase
    end

    // ro_en comes from a flop fed by the next state so the enable gate never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            roEnReg <= 1'b0;
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
        end else begin
            state   <= nextState;
            roEnReg <= (nextState == SETTLE) || (nextState == COUNT);
            sync1   <= ro_out;
            sync2   <= sync1;
            sync3   <= sync2;
            if (nextState != state) begin
                timer <= loadVal;
            end else if (timer != '0) begin
                timer <= timer - TIMER_W'(1);
            end
        end
    end

    // Results are captured on the way into DONE so they are valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winLat    <= '0;
            edgeCount <= '0;
            ovfCount  <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (state == IDLE && start && !abort) begin
                winLat    <= window_len;
                edgeCount <= '0;
                ovfCount  <= 1'b0;
            end else if (state == COUNT && riseDet) begin
                if (edgeCount == COUNT_MAX) begin
                    ovfCount <= 1'b1;
                end else begin
                    edgeCount <= edgeCount + COUNT_W'(1);
                end
            end
            if (state == DRAIN && nextState == DONE) begin
                result   <= edgeCount;
                overflow <= ovfCount;
            end
        end
    end

endmodule
